trigger_link_startup: RTL and testbench

- Power-up and recovery sequencer for the four trigger-link GTX transmitters (CSC right/left, GEM right/left).
- Drives the shared TX PLL reset and the shared GTX TX reset. Waits for PLL lock and TX reset-done on every enabled link, then asserts link_ready.
- Monitors lock while running and automatically restarts the sequence on loss of lock.
- Runs on clk_40 and replaces the fixed SRL16 power-up reset.

---
 rtl/trigger_link_startup.sv | 166 ++++++++++++++++
 tb/tb_trigger_link_startup.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_link_startup.sv
// ============================================================================
// Module      : trigger_link_startup
// Description : Power-up / recovery sequencer for the four trigger-link GTX
//               transmitters: PLL reset, lock wait, TX reset, done wait, settle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_link_startup #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int GTX_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int DONE_TIMEOUT   = 4096,
    parameter int SETTLE_CYCLES  = 64,
    parameter int CNT_W          = 13
) (
    input  logic       clk_40,
    input  logic       reset_n,
    input  logic [3:0] link_mask,
    input  logic       restart,
    input  logic [3:0] tx_pll_locked,
    input  logic [3:0] tx_reset_done,
    output logic       txpll_rst,
    output logic       gtx_tx_rst,
    output logic       link_ready,
    output logic [2:0] state,
    output logic [7:0] relock_cnt,
    output logic [7:0] timeout_cnt
);

    localparam logic [2:0] c_PLL_RST   = 3'd0;
    localparam logic [2:0] c_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_GTX_RST   = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_SETTLE    = 3'd4;
    localparam logic [2:0] c_READY     = 3'd5;

    localparam logic [CNT_W-1:0] c_PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GTX_LAST    = CNT_W'(GTX_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_DONE_LAST   = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]       r_lock_s1, r_lock_s2, r_done_s1, r_done_s2;
    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic             r_lock_miss;
    logic             r_txpll_rst, r_gtx_tx_rst, r_link_ready;
    logic [7:0]       r_relock_cnt, r_timeout_cnt;
    logic             w_lock_ok, w_done_ok, w_relock_inc, w_timeout_inc;

    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_s1 <= '0;
            r_lock_s2 <= '0;
            r_done_s1 <= '0;
            r_done_s2 <= '0;
        end else begin
            r_lock_s1 <= tx_pll_locked;
            r_lock_s2 <= r_lock_s1;
            r_done_s1 <= tx_reset_done;
            r_done_s2 <= r_done_s1;
        end
    end

    // An empty mask must never look "all good".
    assign w_lock_ok = (|link_mask) & (&(r_lock_s2 | ~link_mask));
    assign w_done_ok = (|link_mask) & (&(r_done_s2 | ~link_mask));

    always_comb begin
        w_state_nxt   = r_state;
        w_relock_inc  = 1'b0;
        w_timeout_inc = 1'b0;
        case (r_state)
            c_PLL_RST: begin
                if (r_timer == c_PLL_LAST) w_state_nxt = c_WAIT_LOCK;
            end
            c_WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_state_nxt = c_GTX_RST;
                end else if (r_timer == c_LOCK_LAST) begin
                    w_state_nxt   = c_PLL_RST;
                    w_timeout_inc = 1'b1;
                end
            end
            c_GTX_RST: begin
                if (r_timer == c_GTX_LAST) w_state_nxt = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (w_done_ok) begin
                    w_state_nxt = c_SETTLE;
                end else if (r_timer == c_DONE_LAST) begin
                    w_state_nxt   = c_GTX_RST;
                    w_timeout_inc = 1'b1;
                end
            end
            c_SETTLE: begin
                if (!w_lock_ok) begin
                    w_state_nxt  = c_PLL_RST;
                    w_relock_inc = 1'b1;
                end else if (r_timer == c_SETTLE_LAST) begin
                    w_state_nxt = c_READY;
                end
            end
            c_READY: begin
                // A pending lock miss masks done loss so lock loss wins.
                if (!w_lock_ok) begin
                    if (r_lock_miss) begin
                        w_state_nxt  = c_PLL_RST;
                        w_relock_inc = 1'b1;
                    end
                end else if (!w_done_ok) begin
                    w_state_nxt = c_GTX_RST;
                end
            end
            default: w_state_nxt = c_PLL_RST;
        endcase
        if (restart) begin
            w_state_nxt   = c_PLL_RST;
            w_relock_inc  = 1'b0;
            w_timeout_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_PLL_RST;
            r_timer       <= '0;
            r_lock_miss   <= 1'b0;
            r_txpll_rst   <= 1'b1;
            r_gtx_tx_rst  <= 1'b1;
            r_link_ready  <= 1'b0;
            r_relock_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (restart || (w_state_nxt != r_state)) begin
                r_timer <= '0;
            end else if (r_timer != {CNT_W{1'b1}}) begin
                r_timer <= r_timer + 1'b1;
            end
            r_lock_miss  <= (r_state == c_READY) && (w_state_nxt == c_READY) && !w_lock_ok;
            // Outputs decoded from the next state so they line up with r_state.
            r_txpll_rst  <= (w_state_nxt == c_PLL_RST);
            r_gtx_tx_rst <= (w_state_nxt == c_PLL_RST) || (w_state_nxt == c_WAIT_LOCK) ||
                            (w_state_nxt == c_GTX_RST);
            r_link_ready <= (w_state_nxt == c_READY);
            if (w_relock_inc && (r_relock_cnt != 8'hFF)) begin
                r_relock_cnt <= r_relock_cnt + 8'd1;
            end
            if (w_timeout_inc && (r_timeout_cnt != 8'hFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
        end
    end

    assign txpll_rst   = r_txpll_rst;
    assign gtx_tx_rst  = r_gtx_tx_rst;
    assign link_ready  = r_link_ready;
    assign state       = r_state;
    assign relock_cnt  = r_relock_cnt;
    assign timeout_cnt = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trigger_link_startup.sv
// ============================================================================
// Module      : tb_trigger_link_startup
// Description : Directed scoreboard bench for trigger_link_startup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_link_startup;

    localparam logic [2:0] c_PLL_RST   = 3'd0;
    localparam logic [2:0] c_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_GTX_RST   = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_SETTLE    = 3'd4;
    localparam logic [2:0] c_READY     = 3'd5;

    logic       clk_40 = 1'b0;
    logic       reset_n;
    logic [3:0] link_mask;
    logic       restart;
    logic [3:0] tx_pll_locked;
    logic [3:0] tx_reset_done;
    logic       txpll_rst, gtx_tx_rst, link_ready;
    logic [2:0] state;
    logic [7:0] relock_cnt, timeout_cnt;

    trigger_link_startup dut (
        .clk_40        (clk_40),
        .reset_n       (reset_n),
        .link_mask     (link_mask),
        .restart       (restart),
        .tx_pll_locked (tx_pll_locked),
        .tx_reset_done (tx_reset_done),
        .txpll_rst     (txpll_rst),
        .gtx_tx_rst    (gtx_tx_rst),
        .link_ready    (link_ready),
        .state         (state),
        .relock_cnt    (relock_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk_40 = ~clk_40;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [21:0] obs;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_rel = 8'd0;
    logic [7:0] m_to  = 8'd0;

    // Monitor: one expectation popped and compared per falling edge.
    always @(negedge clk_40) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            obs = {state, link_ready, txpll_rst, gtx_tx_rst, relock_cnt, timeout_cnt};
            n_checks++;
            if (obs !== mon_e.v) begin
                n_errors++;
                $display("FAIL %s: got st=%0d rdy=%0b pllrst=%0b gtxrst=%0b relock=%0d tmo=%0d, want st=%0d rdy=%0b pllrst=%0b gtxrst=%0b relock=%0d tmo=%0d",
                         mon_e.name, obs[21:19], obs[18], obs[17], obs[16], obs[15:8], obs[7:0],
                         mon_e.v[21:19], mon_e.v[18], mon_e.v[17], mon_e.v[16], mon_e.v[15:8], mon_e.v[7:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_40);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [2:0] st);
        exp_t e;
        logic lr, txp, gtx;
        txp = (st == c_PLL_RST);
        gtx = (st == c_PLL_RST) || (st == c_WAIT_LOCK) || (st == c_GTX_RST);
        lr  = (st == c_READY);
        e.name = name;
        e.v    = {st, lr, txp, gtx, m_rel, m_to};
        sb_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k;
        k = 0;
        while ((state !== s) && (k < budget)) begin
            step(1);
            k++;
        end
        if (state !== s) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, state, k, s);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        restart       = 1'b0;
        link_mask     = 4'hF;
        tx_pll_locked = 4'h0;
        tx_reset_done = 4'h0;
        step(3);
        expect_out("reset", c_PLL_RST);
        step(1);
        reset_n = 1'b1;

        // Nominal bring-up, cycle-exact.
        step(15); expect_out("pll_rst_hold", c_PLL_RST);
        step(1);  expect_out("pll_rst_end", c_WAIT_LOCK);
        step(14); tx_pll_locked = 4'hF; expect_out("wait_lock", c_WAIT_LOCK);
        step(2);  expect_out("lock_sync", c_WAIT_LOCK);
        step(1);  expect_out("gtx_rst_enter", c_GTX_RST);
        step(7);  expect_out("gtx_rst_hold", c_GTX_RST);
        step(1);  expect_out("wait_done", c_WAIT_DONE);
        step(20); tx_reset_done = 4'hF; expect_out("done_rise", c_WAIT_DONE);
        step(3);  expect_out("settle_enter", c_SETTLE);
        step(63); expect_out("settle_end", c_SETTLE);
        step(1);  expect_out("ready_exact", c_READY);

        // Lock timeout on link 2, twice, then mask it out.
        tx_pll_locked = 4'b1011;
        restart = 1'b1;
        step(1);  restart = 1'b0; expect_out("restart_ready", c_PLL_RST);
        step(15); expect_out("pll_rst_2", c_PLL_RST);
        step(1);  expect_out("wait_lock_2", c_WAIT_LOCK);
        step(4095); expect_out("lock_tmo_edge", c_WAIT_LOCK);
        step(1);  m_to = 8'd1; expect_out("lock_tmo_1", c_PLL_RST);
        step(16); expect_out("wait_lock_3", c_WAIT_LOCK);
        step(4095);
        step(1);  m_to = 8'd2; expect_out("lock_tmo_2", c_PLL_RST);
        link_mask = 4'hB;
        wait_state(c_READY, 200, "masked_bringup");
        expect_out("masked_ready", c_READY);
        tx_pll_locked = 4'hF;
        step(3);  link_mask = 4'hF;
        step(2);  expect_out("unmask_ready", c_READY);

        // Lock glitch ignored; sustained loss restarts.
        tx_pll_locked = 4'b1110;
        step(1);  tx_pll_locked = 4'hF;
        step(5);  expect_out("lock_glitch", c_READY);
        tx_pll_locked = 4'b1110;
        step(3);  expect_out("lock_loss_q", c_READY);
        step(1);  m_rel = 8'd1; expect_out("lock_loss", c_PLL_RST);
        step(1);  tx_pll_locked = 4'hF;
        wait_state(c_READY, 300, "relock_bringup");
        expect_out("relock_ready", c_READY);

        // Done loss alone, then lock and done lost together.
        tx_reset_done = 4'b1101;
        step(2);  expect_out("done_loss_q", c_READY);
        step(1);  expect_out("done_loss", c_GTX_RST);
        tx_reset_done = 4'hF;
        wait_state(c_READY, 300, "redone_bringup");
        expect_out("redone_ready", c_READY);
        tx_pll_locked = 4'b1110;
        tx_reset_done = 4'b1110;
        step(3);  expect_out("both_loss_q", c_READY);
        tx_pll_locked = 4'hF;
        tx_reset_done = 4'hF;
        step(1);  m_rel = 8'd2; expect_out("both_loss", c_PLL_RST);
        wait_state(c_READY, 300, "both_bringup");

        // Restart in WAIT_DONE, held for three cycles.
        tx_reset_done = 4'h0;
        wait_state(c_WAIT_DONE, 50, "to_wait_done");
        expect_out("in_wait_done", c_WAIT_DONE);
        restart = 1'b1;
        step(1);  expect_out("restart_wd", c_PLL_RST);
        step(2);  restart = 1'b0;
        step(15); expect_out("restart_hold", c_PLL_RST);
        step(1);  expect_out("restart_release", c_WAIT_LOCK);
        tx_reset_done = 4'hF;
        wait_state(c_READY, 300, "restart_bringup");

        // Asynchronous reset in READY, between clock edges.
        #2;
        reset_n = 1'b0;
        m_rel = 8'd0;
        m_to  = 8'd0;
        expect_out("async_rst", c_PLL_RST);
        step(2);
        reset_n = 1'b1;
        wait_state(c_READY, 300, "post_reset_bringup");
        expect_out("post_reset_ready", c_READY);

        // 300 lock losses out of SETTLE saturate relock_cnt.
        restart = 1'b1;
        step(1);  restart = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wait_state(c_SETTLE, 100, "sat_settle");
            tx_pll_locked = 4'h0;
            wait_state(c_PLL_RST, 10, "sat_loss");
            tx_pll_locked = 4'hF;
            if (m_rel != 8'hFF) m_rel = m_rel + 8'd1;
            if (i == 99 || i == 254 || i == 299) expect_out("relock_sat", c_PLL_RST);
            step(1);
        end

        // Empty mask: periodic lock timeouts, never ready.
        link_mask = 4'h0;
        restart = 1'b1;
        step(1);  restart = 1'b0; expect_out("mask0_start", c_PLL_RST);
        step(16); expect_out("mask0_wait", c_WAIT_LOCK);
        step(4095); expect_out("mask0_edge", c_WAIT_LOCK);
        step(1);  m_to = 8'd1; expect_out("mask0_tmo_1", c_PLL_RST);
        step(4111); expect_out("mask0_edge2", c_WAIT_LOCK);
        step(1);  m_to = 8'd2; expect_out("mask0_tmo_2", c_PLL_RST);

        step(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
